// File: rtl/servant_uart_monitor.sv
// 8N1 UART receive decoder for the servant GPIO line: byte strobes, framing
// error strobes and a wrapping received-byte counter.
module servant_uart_monitor #(
  parameter int clks_per_bit = 556,
  parameter int cnt_width    = 16
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 q,
  output logic [7:0]           rx_data,
  output logic                 rx_vld,
  output logic                 rx_ferr,
  output logic                 rx_busy,
  output logic [cnt_width-1:0] rx_cnt
);

  localparam int tw = $clog2(clks_per_bit);
  localparam logic [tw-1:0] full_ld = tw'(clks_per_bit - 1);
  localparam logic [tw-1:0] half_ld = tw'(clks_per_bit / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 sync1_q, qs_q;
  logic [2:0]           state_q, state_d;
  logic [tw-1:0]        tmr_q, tmr_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           sh_q, sh_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_vld_q, rx_vld_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic [cnt_width-1:0] rx_cnt_q, rx_cnt_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = (tmr_q != '0) ? tmr_q - tw'(1) : tmr_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    rx_ferr_d = 1'b0;
    rx_cnt_d  = rx_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!qs_q) begin
          state_d = S_START;
          tmr_d   = half_ld;
        end
      end
      S_START: begin
        if (tmr_q == '0) begin
          if (!qs_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
            tmr_d   = full_ld;
          end else begin
            // Start bit gone by mid-bit: a glitch, drop it silently.
            state_d = S_IDLE;
            tmr_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (tmr_q == '0) begin
          sh_d  = {qs_q, sh_q[7:1]};
          tmr_d = full_ld;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tmr_q == '0) begin
          tmr_d = '0;
          if (qs_q) begin
            state_d   = S_IDLE;
            rx_data_d = sh_q;
            rx_vld_d  = 1'b1;
            rx_cnt_d  = rx_cnt_q + cnt_width'(1);
          end else begin
            state_d   = S_BREAK;
            rx_ferr_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it cannot retrigger frames.
        if (qs_q) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      sync1_q   <= 1'b1;
      qs_q      <= 1'b1;
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_q     <= 3'd0;
      sh_q      <= 8'h00;
      rx_data_q <= 8'h00;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_cnt_q  <= '0;
    end else begin
      sync1_q   <= q;
      qs_q      <= sync1_q;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rx_data_q <= rx_data_d;
      rx_vld_q  <= rx_vld_d;
      rx_ferr_q <= rx_ferr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign rx_ferr = rx_ferr_q;
  assign rx_busy = (state_q != S_IDLE);
  assign rx_cnt  = rx_cnt_q;

endmodule

// File: tb/tb_servant_uart_monitor.sv
// Bench for servant_uart_monitor at 16 clocks/bit: table frames, hand-built
// corner sequences and a random line checked against a frame-level model.
module tb_servant_uart_monitor;
  localparam int C  = 16;
  localparam int NR = 8000;

  logic        wb_clk = 1'b0, wb_rst = 1'b1, q = 1'b1;
  logic [7:0]  rx_data, rx_data4;
  logic        rx_vld, rx_ferr, rx_busy, rx_vld4, rx_ferr4, rx_busy4;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_cnt4;

  servant_uart_monitor #(.clks_per_bit(C), .cnt_width(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .q(q), .rx_data(rx_data), .rx_vld(rx_vld),
    .rx_ferr(rx_ferr), .rx_busy(rx_busy), .rx_cnt(rx_cnt));
  servant_uart_monitor #(.clks_per_bit(C), .cnt_width(4)) dut4 (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .q(q), .rx_data(rx_data4), .rx_vld(rx_vld4),
    .rx_ferr(rx_ferr4), .rx_busy(rx_busy4), .rx_cnt(rx_cnt4));

  always #5 wb_clk = ~wb_clk;

  typedef struct { int cyc; bit ferr; logic [7:0] data; } ev_t;
  typedef struct {
    logic [7:0] b; bit stop; int hold; bit exp_ferr; logic [7:0] exp_data; int exp_cnt;
  } vec_t;

  int  cyc = 0;
  ev_t ev_q[$];
  ev_t exp_q[$];
  int  n_vld4 = 0;
  bit  both_hi = 1'b0;
  int  nvec = 0, nerr = 0;
  int  eb = 0;
  bit  qv [NR];

  always @(posedge wb_clk) cyc <= cyc + 1;

  always @(posedge wb_clk) begin
    ev_t e;
    #1;
    if (rx_vld || rx_ferr) begin
      e.cyc = cyc; e.ferr = rx_ferr; e.data = rx_data;
      ev_q.push_back(e);
    end
    if (rx_vld4) n_vld4 = n_vld4 + 1;
    if ((rx_vld && rx_ferr) || (rx_vld4 && rx_ferr4)) both_hi = 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic ev_t get_ev(input int k);
    ev_t e;
    e.cyc = -1; e.ferr = 1'b0; e.data = 8'h00;
    if (eb + k < ev_q.size()) e = ev_q[eb + k];
    return e;
  endfunction

  function automatic int nev();
    return ev_q.size() - eb;
  endfunction

  task automatic drive(input logic v);
    q = v;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  task automatic send(input logic [7:0] b, input bit stop, input int hold, output int t0);
    t0 = cyc;
    for (int i = 0; i < C; i++) drive(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < C; i++) drive(b[k]);
    for (int i = 0; i < C; i++) drive(stop);
    for (int i = 0; i < hold; i++) drive(1'b0);
    q = 1'b1;
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    drive(1'b1); drive(1'b1);
    wb_rst = 1'b0;
    idle(5);
  endtask

  // Frame-level reference: walk the line sample array, locate start bits
  // when the receiver is free, and read each bit at its mid-bit sample.
  task automatic model(input int base);
    int t, avail, s, b0;
    logic [7:0] b, last;
    ev_t e;
    t = 0; avail = 0; last = 8'h00;
    exp_q.delete();
    while (t < NR) begin
      if (t >= avail && !qv[t]) begin
        if (t + C/2 + 9*C >= NR) break;
        if (qv[t + C/2]) avail = t + 1 + C/2;
        else begin
          for (int k = 0; k < 8; k++) b[k] = qv[t + C/2 + (k+1)*C];
          s = t + 2 + C/2 + 9*C;
          e.cyc = base + 1 + s;
          if (qv[t + C/2 + 9*C]) begin
            last = b; e.ferr = 1'b0; e.data = b; avail = s - 1;
          end else begin
            e.ferr = 1'b1; e.data = last;
            b0 = s - 1;
            while (b0 < NR && !qv[b0]) b0++;
            avail = b0 + 1;
          end
          exp_q.push_back(e);
        end
        t = avail;
      end else t++;
    end
  endtask

  initial begin
    vec_t tbl [6];
    ev_t  e;
    int   t0, t1, g0, r, fall, base, i, nv, v4b;
    bit   seen;
    logic [7:0] fr, rb;

    tbl[0] = '{8'h00, 1'b1, 0, 1'b0, 8'h00, 3};
    tbl[1] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF, 4};
    tbl[2] = '{8'h81, 1'b0, 5, 1'b1, 8'hFF, 4};
    tbl[3] = '{8'h7E, 1'b1, 0, 1'b0, 8'h7E, 5};
    tbl[4] = '{8'hC3, 1'b0, 0, 1'b1, 8'h7E, 5};
    tbl[5] = '{8'h01, 1'b1, 0, 1'b0, 8'h01, 6};

    wb_rst = 1'b1;
    drive(1'b1); drive(1'b1); drive(1'b1);
    wb_rst = 1'b0;
    idle(100);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_vld", rx_vld, 0);
    chk("rst_ferr", rx_ferr, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_cnt", rx_cnt, 0);
    chk("rst_no_ev", nev(), 0);

    // Back-to-back 0x55, 0xA3.
    eb = ev_q.size();
    send(8'h55, 1'b1, 0, t0);
    send(8'hA3, 1'b1, 0, t1);
    idle(20);
    chk("b2b_nev", nev(), 2);
    e = get_ev(0);
    chk("b2b_lat0", e.cyc - t0, 155);
    chk("b2b_data0", e.data, 8'h55);
    e = get_ev(1);
    chk("b2b_lat1", e.cyc - t0, 315);
    chk("b2b_data1", e.data, 8'hA3);
    chk("b2b_cnt", rx_cnt, 2);

    // 5-cycle low glitch.
    eb = ev_q.size();
    g0 = cyc; seen = 1'b0; fall = -1;
    for (int k = 0; k < 40; k++) begin
      drive(k < 5 ? 1'b0 : 1'b1);
      if (rx_busy) seen = 1'b1;
      else if (seen && fall < 0) fall = cyc - g0;
    end
    chk("glitch_busy_fall", fall, 3 + C/2);
    chk("glitch_nev", nev(), 0);
    chk("glitch_cnt", rx_cnt, 2);

    // Stop bit low, line held low, then released.
    eb = ev_q.size();
    send(8'h3C, 1'b0, 40, t0);
    chk("brk_busy_held", rx_busy, 1);
    r = cyc;
    drive(1'b1); drive(1'b1);
    chk("brk_busy_r2", rx_busy, 1);
    drive(1'b1);
    chk("brk_exit_r3", rx_busy, 0);
    chk("brk_exit_cyc", cyc - r, 3);
    idle(10);
    chk("brk_nev", nev(), 1);
    e = get_ev(0);
    chk("brk_ferr", e.ferr, 1);
    chk("brk_lat", e.cyc - t0, 155);
    chk("brk_data_held", rx_data, 8'hA3);
    chk("brk_cnt", rx_cnt, 2);

    for (int k = 0; k < 6; k++) begin
      eb = ev_q.size();
      send(tbl[k].b, tbl[k].stop, tbl[k].hold, t0);
      idle(8);
      e = get_ev(0);
      chk($sformatf("tbl%0d_nev", k), nev(), 1);
      chk($sformatf("tbl%0d_ferr", k), e.ferr, tbl[k].exp_ferr);
      chk($sformatf("tbl%0d_lat", k), e.cyc - t0, 155);
      chk($sformatf("tbl%0d_data", k), rx_data, tbl[k].exp_data);
      chk($sformatf("tbl%0d_cnt", k), rx_cnt, tbl[k].exp_cnt);
      chk($sformatf("tbl%0d_busy", k), rx_busy, 0);
    end

    // Reset at cycle 80 of a frame.
    eb = ev_q.size();
    fr = 8'hF0;
    for (int k = 0; k < 80; k++) drive((k / C) == 0 ? 1'b0 : fr[(k / C) - 1]);
    wb_rst = 1'b1;
    drive(1'b1); drive(1'b1); drive(1'b1);
    wb_rst = 1'b0;
    idle(200);
    chk("midrst_nev", nev(), 0);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_cnt", rx_cnt, 0);
    chk("midrst_busy", rx_busy, 0);
    send(8'h0F, 1'b1, 0, t0);
    idle(5);
    chk("midrst_next_nev", nev(), 1);
    chk("midrst_next_data", rx_data, 8'h0F);
    chk("midrst_next_cnt", rx_cnt, 1);

    // 17 bytes into the 4-bit counter instance.
    do_reset();
    v4b = n_vld4;
    for (int k = 0; k < 17; k++) send(8'h41, 1'b1, 0, t0);
    idle(5);
    chk("wrap_pulses", n_vld4 - v4b, 17);
    chk("wrap_cnt4", rx_cnt4, 1);
    chk("wrap_data4", rx_data4, 8'h41);
    chk("wrap_busy4", rx_busy4, 0);
    chk("wrap_cnt16", rx_cnt, 17);

    // Random line.
    do_reset();
    i = 0;
    for (int k = 0; k < 40; k++) begin qv[i] = 1'b1; i++; end
    while (i < NR - 400) begin
      int kind, gap, len, hold;
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 12);
      for (int k = 0; k < gap; k++) begin qv[i] = 1'b1; i++; end
      if (kind < 2) begin
        len = $urandom_range(1, 12);
        for (int k = 0; k < len; k++) begin qv[i] = 1'b0; i++; end
      end else begin
        rb = 8'($urandom);
        for (int k = 0; k < C; k++) begin qv[i] = 1'b0; i++; end
        for (int j = 0; j < 8; j++)
          for (int k = 0; k < C; k++) begin qv[i] = rb[j]; i++; end
        for (int k = 0; k < C; k++) begin qv[i] = (kind != 2); i++; end
        hold = (kind == 2) ? $urandom_range(0, 30) : 0;
        for (int k = 0; k < hold; k++) begin qv[i] = 1'b0; i++; end
      end
    end
    while (i < NR) begin qv[i] = 1'b1; i++; end

    eb = ev_q.size();
    base = cyc;
    for (int k = 0; k < NR; k++) drive(qv[k]);
    model(base);
    chk("rnd_nev", nev(), exp_q.size());
    nv = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = get_ev(k);
      chk($sformatf("rnd%0d_cyc", k), e.cyc, exp_q[k].cyc);
      chk($sformatf("rnd%0d_ferr", k), e.ferr, exp_q[k].ferr);
      chk($sformatf("rnd%0d_data", k), e.data, exp_q[k].data);
      if (!exp_q[k].ferr) nv++;
    end
    chk("rnd_cnt", rx_cnt, nv);
    chk("rnd_busy", rx_busy, 0);

    chk("vld_ferr_exclusive", both_hi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
